aer_event_tx: RTL and testbench

- Transmit end of the pixel-hierarchy arbitration path.
- Captures each granted event (group row/col from the level-1 arbiter, pixel row/col from the granted level-0 group), forms a full 16x16 address, and timestamps it.
- Buffers events in a small FIFO and drives them off-block over a 4-phase req/ack AER handshake.
- Returns a one-cycle grp_release_o pulse so the arbiter hierarchy can advance to the next request.

---
 rtl/aer_pkg.sv | 15 +
 rtl/aer_evt_fifo.sv | 45 ++++
 rtl/aer_event_tx.sv | 87 ++++++++
 tb/tb_aer_event_tx.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/aer_pkg.sv
// aer_pkg: shared types and constants for the AER transmit block
package aer_pkg;
  localparam int ADDR_W = 9;
  localparam int GRID = 16;
  localparam int TS_MAX = 32;
  typedef enum logic {CAP_IDLE, CAP_REL} cap_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_REQ, TX_ACKLO} tx_state_t;
  // ts is stored at TS_MAX bits; the top zero-extends its TS_W counter into it
  typedef struct packed {
    logic                      pol;
    logic [$clog2(GRID)-1:0]   row;
    logic [$clog2(GRID)-1:0]   col;
    logic [TS_MAX-1:0]         ts;
  } aer_evt_t;
endpackage

// File: rtl/aer_evt_fifo.sv
// aer_evt_fifo: circular event buffer with registered full/empty flags
//   grp_release_clk, rst_n : clock, async active-high reset
//   push_i/din_i           : write one event (caller guarantees space)
//   pop_i/dout_o           : dout_o shows the head; pop_i advances it
//   full_o/empty_o         : registered from the next-state count
module aer_evt_fifo
  import aer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     grp_release_clk,
  input  logic     rst_n,
  input  logic     push_i,
  input  aer_evt_t din_i,
  input  logic     pop_i,
  output aer_evt_t dout_o,
  output logic     full_o,
  output logic     empty_o
);
  localparam int AW = $clog2(DEPTH);
  aer_evt_t mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q, cnt_d;
  logic full_q, empty_q;
  assign cnt_d = cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
  always_ff @(posedge grp_release_clk or posedge rst_n)
    if (rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wr_q    <= wr_q + AW'(push_i);
      rd_q    <= rd_q + AW'(pop_i);
      cnt_q   <= cnt_d;
      full_q  <= cnt_d == (AW+1)'(DEPTH);
      empty_q <= cnt_d == '0;
    end
  always_ff @(posedge grp_release_clk)
    if (push_i) mem_q[wr_q] <= din_i;
  assign dout_o  = mem_q[rd_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
endmodule

// File: rtl/aer_event_tx.sv
// aer_event_tx: captures granted pixel events, timestamps, buffers and sends them over 4-phase AER
//   grp_release_clk, rst_n            : clock, async active-high reset
//   grp_valid_i, grp_x/y_i, pix_x/y_i : granted group and pixel coordinates, pol_i polarity
//   aer_req_o/aer_ack_i               : 4-phase handshake, aer_addr_o/aer_ts_o event payload
//   grp_release_o                     : one-cycle pulse after each capture
//   fifo_full_o/fifo_empty_o          : buffer status, evt_sent_o saturating handshake count
module aer_event_tx
  import aer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TS_W       = 16,
  parameter int CNT_W      = 16
) (
  input  logic              grp_release_clk,
  input  logic              rst_n,
  input  logic              grp_valid_i,
  input  logic [1:0]        grp_x_i,
  input  logic [1:0]        grp_y_i,
  input  logic [1:0]        pix_x_i,
  input  logic [1:0]        pix_y_i,
  input  logic              pol_i,
  input  logic              aer_ack_i,
  output logic              aer_req_o,
  output logic [ADDR_W-1:0] aer_addr_o,
  output logic [TS_W-1:0]   aer_ts_o,
  output logic              grp_release_o,
  output logic              fifo_full_o,
  output logic              fifo_empty_o,
  output logic [CNT_W-1:0]  evt_sent_o
);
  cap_state_t cap_q, cap_d;
  tx_state_t tx_q, tx_d;
  logic [TS_W-1:0] ts_q, aer_ts_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0] sent_q;
  aer_evt_t evt_in, head;
  logic push, pop;
  assign pop    = tx_q == TX_IDLE && !fifo_empty_o;
  // a same-cycle pop frees a slot, so a full buffer can still accept
  assign push   = cap_q == CAP_IDLE && grp_valid_i && (!fifo_full_o || pop);
  assign evt_in = '{pol: pol_i, row: {grp_x_i, pix_x_i}, col: {grp_y_i, pix_y_i}, ts: TS_MAX'(ts_q)};
  aer_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .grp_release_clk(grp_release_clk),
    .rst_n          (rst_n),
    .push_i         (push),
    .din_i          (evt_in),
    .pop_i          (pop),
    .dout_o         (head),
    .full_o         (fifo_full_o),
    .empty_o        (fifo_empty_o)
  );
  always_ff @(posedge grp_release_clk or posedge rst_n)
    if (rst_n) begin
      cap_q <= CAP_IDLE;
      tx_q  <= TX_IDLE;
    end else begin
      cap_q <= cap_d;
      tx_q  <= tx_d;
    end
  // CAP_REL blocks recapture of the grant while the arbiter advances
  always_comb cap_d = cap_q == CAP_IDLE && push ? CAP_REL : CAP_IDLE;
  always_comb
    tx_d = tx_q == TX_IDLE ? (pop ? TX_REQ : TX_IDLE) :
           tx_q == TX_REQ  ? (aer_ack_i ? TX_ACKLO : TX_REQ) :
                             (aer_ack_i ? TX_ACKLO : TX_IDLE);
  always_comb begin
    grp_release_o = cap_q == CAP_REL;
    aer_req_o     = tx_q == TX_REQ;
  end
  always_ff @(posedge grp_release_clk or posedge rst_n)
    if (rst_n) begin
      ts_q     <= '0;
      addr_q   <= '0;
      aer_ts_q <= '0;
      sent_q   <= '0;
    end else begin
      ts_q <= ts_q + TS_W'(1);
      if (pop) begin
        addr_q   <= {head.pol, head.row, head.col};
        aer_ts_q <= TS_W'(head.ts);
      end
      if (tx_q == TX_REQ && aer_ack_i && !(&sent_q)) sent_q <= sent_q + CNT_W'(1);
    end
  assign aer_addr_o = addr_q;
  assign aer_ts_o   = aer_ts_q;
  assign evt_sent_o = sent_q;
endmodule

// File: tb/tb_aer_event_tx.sv
// tb_aer_event_tx: directed scoreboard bench for aer_event_tx
module tb_aer_event_tx;
  logic clk = 1'b0, rst_n = 1'b1, grp_valid_i = 1'b0, pol_i = 1'b0, aer_ack_i = 1'b0;
  logic [1:0] gx = '0, gy = '0, px = '0, py = '0;
  logic aer_req_o, grp_release_o, fifo_full_o, fifo_empty_o;
  logic [8:0] aer_addr_o;
  logic [3:0] aer_ts_o;
  logic [15:0] evt_sent_o;
  int checks = 0, errors = 0, rel_cnt = 0, ack_mode = 0, r0;
  logic [3:0] model_ts, t1_ts;
  logic [12:0] sb [$];
  logic [12:0] exp_evt;
  logic prev_req = 1'b0, ok;

  aer_event_tx #(.FIFO_DEPTH(4), .TS_W(4), .CNT_W(16)) dut (
    .grp_release_clk(clk), .rst_n(rst_n), .grp_valid_i(grp_valid_i),
    .grp_x_i(gx), .grp_y_i(gy), .pix_x_i(px), .pix_y_i(py), .pol_i(pol_i),
    .aer_ack_i(aer_ack_i), .aer_req_o(aer_req_o), .aer_addr_o(aer_addr_o),
    .aer_ts_o(aer_ts_o), .grp_release_o(grp_release_o), .fifo_full_o(fifo_full_o),
    .fifo_empty_o(fifo_empty_o), .evt_sent_o(evt_sent_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst_n)
    if (rst_n) model_ts <= '0;
    else model_ts <= model_ts + 4'd1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!aer_req_o && n < 10) begin @(negedge clk); n++; end
    if (!aer_req_o) begin
      checks++; errors++;
      $error("FAIL %s: req timeout got 0 expected 1", tag);
    end
  endtask

  task automatic wait_ts(input logic [3:0] v);
    int n = 0;
    do begin @(negedge clk); n++; end while (model_ts != v && n < 40);
    if (model_ts != v) begin
      checks++; errors++;
      $error("FAIL wait_ts: got %0h expected %0h", model_ts, v);
    end
  endtask

  // 4-phase receiver: 0 = hold low, 1 = follow req, 2 = hold high
  initial forever begin
    @(posedge clk); #1;
    aer_ack_i = ack_mode == 0 ? 1'b0 : ack_mode == 1 ? aer_req_o : 1'b1;
  end

  // scoreboard: push on release (capture was the previous cycle), pop on req rise
  initial forever begin
    @(posedge clk); #2;
    if (grp_release_o) begin
      rel_cnt++;
      sb.push_back({pol_i, gx, px, gy, py, model_ts - 4'd1});
    end
    if (aer_req_o && !prev_req) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $error("FAIL sb_underflow: got event %0h expected none", {aer_addr_o, aer_ts_o});
      end else begin
        exp_evt = sb.pop_front();
        chk("evt_order", {aer_addr_o, aer_ts_o}, exp_evt);
      end
    end
    prev_req = aer_req_o;
  end

  initial begin
    #50000;
    $error("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_req", aer_req_o, 0);
    chk("rst_addr", aer_addr_o, 0);
    chk("rst_ts", aer_ts_o, 0);
    chk("rst_rel", grp_release_o, 0);
    chk("rst_sent", evt_sent_o, 0);
    chk("rst_full", fifo_full_o, 0);
    chk("rst_empty", fifo_empty_o, 1);
    rst_n = 1'b0;
    // single event, ack follows req
    @(negedge clk);
    ack_mode = 1;
    {gx, gy, px, py, pol_i} = {2'd2, 2'd1, 2'd3, 2'd0, 1'b1};
    grp_valid_i = 1'b1;
    t1_ts = model_ts;
    @(negedge clk);
    chk("t1_release", grp_release_o, 1);
    chk("t1_req_early", aer_req_o, 0);
    grp_valid_i = 1'b0;
    @(negedge clk);
    chk("t1_release_once", grp_release_o, 0);
    chk("t1_req", aer_req_o, 1);
    chk("t1_addr", aer_addr_o, 9'h1B4);
    chk("t1_ts", aer_ts_o, t1_ts);
    repeat (4) @(negedge clk);
    chk("t1_sent", evt_sent_o, 1);
    chk("t1_empty", fifo_empty_o, 1);
    // ack while idle with nothing queued
    ack_mode = 2;
    repeat (4) @(negedge clk);
    chk("t2_no_req", aer_req_o, 0);
    chk("t2_sent", evt_sent_o, 1);
    ack_mode = 0;
    repeat (2) @(negedge clk);
    // backpressure: grant held, receiver stalled
    r0 = rel_cnt;
    {gx, gy, px, py, pol_i} = {2'd0, 2'd3, 2'd1, 2'd2, 1'b0};
    grp_valid_i = 1'b1;
    repeat (20) @(negedge clk);
    chk("t3_captures", rel_cnt - r0, 5);
    chk("t3_full", fifo_full_o, 1);
    chk("t3_no_release", grp_release_o, 0);
    chk("t3_req_held", aer_req_o, 1);
    // full buffer with simultaneous push and pop
    r0 = rel_cnt;
    ack_mode = 1;
    ok = 1'b1;
    repeat (12) begin @(negedge clk); if (!fifo_full_o) ok = 1'b0; end
    chk("t4_full_held", ok, 1);
    chk("t4_push_pop", rel_cnt - r0 >= 3, 1);
    grp_valid_i = 1'b0;
    repeat (30) @(negedge clk);
    chk("t4_empty", fifo_empty_o, 1);
    chk("t4_drained", sb.size(), 0);
    chk("t4_sent", evt_sent_o, rel_cnt);
    // timestamp wrap
    {gx, gy, px, py, pol_i} = {2'd3, 2'd3, 2'd3, 2'd3, 1'b1};
    wait_ts(4'hF);
    grp_valid_i = 1'b1;
    @(negedge clk);
    grp_valid_i = 1'b0;
    wait_req("t5a");
    chk("t5_ts_f", aer_ts_o, 4'hF);
    chk("t5_addr_a", aer_addr_o, 9'h1FF);
    {gx, gy, px, py, pol_i} = {2'd0, 2'd0, 2'd0, 2'd1, 1'b0};
    wait_ts(4'h0);
    grp_valid_i = 1'b1;
    @(negedge clk);
    grp_valid_i = 1'b0;
    wait_req("t5b");
    chk("t5_ts_0", aer_ts_o, 4'h0);
    chk("t5_addr_b", aer_addr_o, 9'h001);
    repeat (4) @(negedge clk);
    // reset in the middle of a handshake
    ack_mode = 0;
    {gx, gy, px, py, pol_i} = {2'd1, 2'd2, 2'd0, 2'd3, 1'b1};
    grp_valid_i = 1'b1;
    wait_req("t6");
    repeat (2) @(negedge clk);
    chk("t6_fifo_loaded", fifo_empty_o, 0);
    rst_n = 1'b1;
    #1;
    chk("t6_req_async", aer_req_o, 0);
    grp_valid_i = 1'b0;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_empty", fifo_empty_o, 1);
    chk("t6_sent", evt_sent_o, 0);
    chk("t6_req", aer_req_o, 0);
    chk("t6_full", fifo_full_o, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
